sme_param: RTL and testbench

Parametrised string-matching engine. Loads a string and a pattern serially, one character per cycle, then searches the stored string for the leftmost match of the pattern. Pattern metacharacters: `^`, `$`, `.` and a single `*`. Next-generation successor of the fixed 32/8 matcher: widths and depths are parameters, the block adds a match-length output, a busy flag and overflow reporting, and a stored string is reusable across several patterns.

---
 rtl/sme_param.sv | 187 ++++++++++++++++++
 tb/tb_sme_param.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sme_param.sv
// Parametrised string-matching engine: serial string/pattern load, then a
// leftmost-match search supporting ^, $, . and a single * metacharacter.
module sme_param #(
    parameter int CHAR_W  = 8,
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    localparam int IW     = $clog2(STR_MAX + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CHAR_W-1:0] chardata,
    input  logic              isstring,
    input  logic              ispattern,
    output logic              busy,
    output logic              valid,
    output logic              match,
    output logic [IW-1:0]     match_index,
    output logic [IW-1:0]     match_len,
    output logic              overflow
);

    localparam int SW = $clog2(STR_MAX);
    localparam int PIW = $clog2(PAT_MAX);
    localparam int PW = $clog2(PAT_MAX + 1);
    localparam int XW = IW + 1;
    localparam logic [IW-1:0] SMAX = IW'(STR_MAX);
    localparam logic [PW-1:0] PMAX = PW'(PAT_MAX);

    typedef enum logic [1:0] {LOAD, SEARCH, DONE} state_t;

    state_t            state_q;
    logic [CHAR_W-1:0] str_q [STR_MAX];
    logic [CHAR_W-1:0] pat_q [PAT_MAX];
    logic [IW-1:0]     slen_q;
    logic [PW-1:0]     plen_q;
    logic              ovf_q;
    logic              restart_q;
    logic [XW-1:0]     s_q;
    logic [XW-1:0]     p_q;

    function automatic logic is_ch(input logic [CHAR_W-1:0] c, input logic [7:0] code);
        return c[7:0] == code;
    endfunction

    function automatic logic [CHAR_W-1:0] str_at(input int unsigned idx);
        logic [CHAR_W-1:0] r;
        r = '0;
        for (int unsigned k = 0; k < STR_MAX; k++)
            if (k == idx) r = str_q[k];
        return r;
    endfunction

    function automatic logic [CHAR_W-1:0] pat_at(input int unsigned idx);
        logic [CHAR_W-1:0] r;
        r = '0;
        for (int unsigned k = 0; k < PAT_MAX; k++)
            if (k == idx) r = pat_q[k];
        return r;
    endfunction

    function automatic logic chr_ok(input logic [CHAR_W-1:0] pc, input logic [CHAR_W-1:0] sc);
        return is_ch(pc, 8'h2E) || (pc == sc);
    endfunction

    int unsigned plen_i, slen_i, s_i, q_i, e_i, b0, blen, star_j, pl, sl;
    logic        a_s, a_e, has_star, pre_ok, suf_ok, fits_s, fits_p;

    // The pattern body splits at the first '*' into a prefix anchored at s and a
    // suffix at q >= s+pl. A failing suffix position fails for every later s,
    // so q only ever advances and each search step moves either s or q.
    always_comb begin
        plen_i   = 32'(plen_q);
        slen_i   = 32'(slen_q);
        s_i      = 32'(s_q);
        a_s      = (plen_i > 0) && is_ch(pat_at(0), 8'h5E);
        b0       = a_s ? 1 : 0;
        a_e      = (plen_i > b0) && is_ch(pat_at(plen_i - 1), 8'h24);
        blen     = plen_i - b0 - (a_e ? 1 : 0);
        has_star = 1'b0;
        star_j   = 0;
        for (int unsigned j = 0; j < PAT_MAX; j++) begin
            if (!has_star && j < blen && is_ch(pat_at(b0 + j), 8'h2A)) begin
                has_star = 1'b1;
                star_j   = j;
            end
        end
        pl = has_star ? star_j : blen;
        sl = has_star ? blen - star_j - 1 : 0;
        q_i = s_i + pl;
        if (has_star && 32'(p_q) > q_i) q_i = 32'(p_q);
        e_i = q_i + sl;

        pre_ok = 1'b1;
        if (a_s && s_i != 0 && !is_ch(str_at(s_i - 1), 8'h20)) pre_ok = 1'b0;
        for (int unsigned j = 0; j < PAT_MAX; j++)
            if (j < pl && !chr_ok(pat_at(b0 + j), str_at(s_i + j))) pre_ok = 1'b0;

        suf_ok = 1'b1;
        for (int unsigned j = 0; j < PAT_MAX; j++)
            if (j < sl && !chr_ok(pat_at(b0 + pl + 1 + j), str_at(q_i + j))) suf_ok = 1'b0;
        if (a_e && e_i != slen_i && !is_ch(str_at(e_i), 8'h20)) suf_ok = 1'b0;

        fits_s = (s_i + pl + sl) <= slen_i;
        fits_p = e_i <= slen_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= LOAD;
            slen_q      <= '0;
            plen_q      <= '0;
            ovf_q       <= 1'b0;
            restart_q   <= 1'b0;
            s_q         <= '0;
            p_q         <= '0;
            busy        <= 1'b0;
            valid       <= 1'b0;
            match       <= 1'b0;
            match_index <= '0;
            match_len   <= '0;
            overflow    <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (isstring) begin
                        if (restart_q) begin
                            str_q[0]  <= chardata;
                            slen_q    <= IW'(1);
                            restart_q <= 1'b0;
                        end else if (slen_q < SMAX) begin
                            str_q[slen_q[SW-1:0]] <= chardata;
                            slen_q <= slen_q + IW'(1);
                        end else begin
                            ovf_q <= 1'b1;
                        end
                    end else if (ispattern) begin
                        if (plen_q < PMAX) begin
                            pat_q[plen_q[PIW-1:0]] <= chardata;
                            plen_q <= plen_q + PW'(1);
                        end else begin
                            ovf_q <= 1'b1;
                        end
                    end else if (plen_q != '0) begin
                        state_q <= SEARCH;
                        busy    <= 1'b1;
                        s_q     <= '0;
                        p_q     <= '0;
                    end
                end
                SEARCH: begin
                    if (!fits_s || (pre_ok && !fits_p)) begin
                        state_q  <= DONE;
                        valid    <= 1'b1;
                        overflow <= ovf_q;
                    end else if (!pre_ok) begin
                        s_q <= XW'(s_i + 1);
                    end else if (suf_ok) begin
                        state_q     <= DONE;
                        valid       <= 1'b1;
                        match       <= 1'b1;
                        match_index <= IW'(s_i);
                        match_len   <= IW'(e_i - s_i);
                        overflow    <= ovf_q;
                    end else if (has_star) begin
                        p_q <= XW'(q_i + 1);
                    end else begin
                        s_q <= XW'(s_i + 1);
                    end
                end
                DONE: begin
                    state_q     <= LOAD;
                    busy        <= 1'b0;
                    valid       <= 1'b0;
                    match       <= 1'b0;
                    match_index <= '0;
                    match_len   <= '0;
                    overflow    <= 1'b0;
                    plen_q      <= '0;
                    ovf_q       <= 1'b0;
                    restart_q   <= 1'b1;
                end
                default: state_q <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_sme_param.sv
// Scoreboard bench for sme_param: stimulus pushes expected results, a monitor
// pops and compares on every valid strobe.
module tb_sme_param;

    localparam int CW = 8;
    localparam int SM = 32;
    localparam int PM = 8;
    localparam int IW = $clog2(SM + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [CW-1:0] chardata = '0;
    logic          isstring = 1'b0;
    logic          ispattern = 1'b0;
    logic          busy, valid, match, overflow;
    logic [IW-1:0] match_index, match_len;

    sme_param #(.CHAR_W(CW), .STR_MAX(SM), .PAT_MAX(PM)) dut (
        .clk(clk), .reset(reset), .chardata(chardata), .isstring(isstring),
        .ispattern(ispattern), .busy(busy), .valid(valid), .match(match),
        .match_index(match_index), .match_len(match_len), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          m;
        int unsigned idx;
        int unsigned len;
        bit          ovf;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    bit          mon_en = 1'b0;
    int unsigned slen_m = 0;
    int unsigned plen_m = 0;

    function automatic void check(input string name, input int unsigned act, input int unsigned req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (valid) begin
                    if (sb.size() == 0) begin
                        check("unexpected_valid", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("match", match, e.m);
                        check("match_index", match_index, e.idx);
                        check("match_len", match_len, e.len);
                        check("overflow", overflow, e.ovf);
                    end
                end else begin
                    check("idle_outputs_zero", {match, match_index, match_len, overflow}, 0);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            chardata = s[i];
            isstring = 1'b1;
            cyc();
        end
        isstring = 1'b0;
        slen_m = (s.len() > SM) ? SM : s.len();
    endtask

    task automatic put_pat(input string p);
        for (int i = 0; i < p.len(); i++) begin
            chardata  = p[i];
            ispattern = 1'b1;
            cyc();
        end
        ispattern = 1'b0;
        plen_m = (p.len() > PM) ? PM : p.len();
    endtask

    // Issues the terminating idle cycle, then waits for valid within the
    // latency bound; junk=1 drives loads throughout the busy window.
    task automatic run(input bit em, input int unsigned ei, input int unsigned el,
                       input bit eo, input bit junk);
        int unsigned bound;
        int unsigned k;
        bit          seen;
        sb.push_back('{em, ei, el, eo});
        bound     = 1 + (slen_m + 1) * (plen_m + 1);
        isstring  = 1'b0;
        ispattern = 1'b0;
        cyc();
        k    = 1;
        seen = 1'b0;
        while (!seen && k < bound) begin
            if (junk) begin
                chardata  = 8'h71;
                isstring  = 1'b1;
                ispattern = 1'b1;
            end
            cyc();
            k++;
            if (valid) seen = 1'b1;
        end
        check("latency_within_bound", seen, 1);
        cyc();
        isstring  = 1'b0;
        ispattern = 1'b0;
    endtask

    initial begin : stim
        string ov;
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_valid", valid, 0);
        check("reset_match", match, 0);
        check("reset_index", match_index, 0);
        check("reset_len", match_len, 0);
        check("reset_overflow", overflow, 0);
        mon_en = 1'b1;

        put_pat(".");     run(1'b0, 0, 0, 1'b0, 1'b0);
        put_pat("*");     run(1'b1, 0, 0, 1'b0, 1'b0);

        put_str("hello world");
        put_pat("wor");   run(1'b1, 6, 3, 1'b0, 1'b0);
        put_pat("^wo");   run(1'b1, 6, 2, 1'b0, 1'b0);
        put_pat("lo$");   run(1'b1, 3, 2, 1'b0, 1'b0);
        put_pat("o.w");   run(1'b1, 4, 3, 1'b0, 1'b0);
        put_pat("xyz");   run(1'b0, 0, 0, 1'b0, 1'b0);
        put_pat("h*o");   run(1'b1, 0, 5, 1'b0, 1'b0);
        put_pat("^*d$");  run(1'b1, 0, 11, 1'b0, 1'b0);

        put_pat("wor");   run(1'b1, 6, 3, 1'b0, 1'b1);
        put_pat("d$");    run(1'b1, 10, 1, 1'b0, 1'b0);

        ov = "";
        for (int i = 0; i < 31; i++) ov = {ov, "b"};
        ov = {ov, "c"};
        for (int i = 0; i < 8; i++) ov = {ov, "x"};
        put_str(ov);
        put_pat("a");     run(1'b0, 0, 0, 1'b1, 1'b0);
        put_pat("c$");    run(1'b1, 31, 1, 1'b0, 1'b0);
        put_pat("bbbbbbbbb"); run(1'b1, 0, 8, 1'b1, 1'b0);
        put_pat("x");     run(1'b0, 0, 0, 1'b0, 1'b0);

        put_pat("zzz");
        cyc();
        cyc();
        cyc();
        check("busy_mid_search", busy, 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        slen_m = 0;
        check("abort_busy", busy, 0);
        check("abort_valid", valid, 0);
        for (int i = 0; i < 40; i++) cyc();

        put_str("ab");
        put_pat("b");     run(1'b1, 1, 1, 1'b0, 1'b0);

        cyc();
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

endmodule
